// File: rtl/systolic_stream_engine.sv
// ---------------------------------------------------------------------------
// systolic_stream_engine
//
// Weight-stationary N x K systolic array. One job computes
// Y[m] = X[m] * W for num_rows input rows. Rows are streamed in over a
// valid/ready handshake and may contain bubbles. Each result row leaves with
// y_valid and its 0-based index on y_row.
//
// Optional feature: define SYSTOLIC_RELU_EN to clamp negative Y elements to 0.
// The clamp is applied after deskew and adds no latency. With the macro
// undefined, Y carries the raw wrapped sum.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active low
//   start     in   one-cycle job request, sampled only in IDLE
//   num_rows  in   rows in the job, captured with start
//   W         in   weights; element (i,j) at W[DATA_WIDTH*(j*N+i) +: DATA_WIDTH]
//   x_valid   in   X row offered
//   x_ready   out  engine accepts X this cycle
//   X         in   input row; element i at X[DATA_WIDTH*i +: DATA_WIDTH]
//   y_valid   out  Y / y_row hold a result this cycle
//   Y         out  result row; element j at Y[ACC_WIDTH*j +: ACC_WIDTH]
//   y_row     out  index of the row currently on Y
//   busy      out  engine is not idle
//   done      out  one-cycle pulse at the end of a job
//
// Latency: a row accepted at clock edge t is presented with y_valid at edge
// t+N+K. Throughput is one row per cycle. There is no output backpressure.
// The array needs N >= 1 and K >= 2.
// ---------------------------------------------------------------------------
module systolic_stream_engine #(
    parameter int N          = 3,
    parameter int K          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int MAX_ROWS   = 256,
    localparam int ROW_W     = $clog2(MAX_ROWS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ROW_W-1:0]            num_rows,
    input  logic [DATA_WIDTH*N*K-1:0]   W,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [DATA_WIDTH*N-1:0]     X,
    output logic                        y_valid,
    output logic [ACC_WIDTH*K-1:0]      Y,
    output logic [ROW_W-1:0]            y_row,
    output logic                        busy,
    output logic                        done
);

    // Edges between the acceptance of a row and the presentation of its result.
    localparam int DEPTH = N + K;
    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [ROW_W-1:0]   num_rows_q_reg;
    logic [ROW_W-1:0]   in_cnt_reg;
    logic [ROW_W-1:0]   out_cnt_reg;
    logic [ROW_W-1:0]   y_row_reg;
    logic [DEPTH-1:0]   valid_pipe_reg;
    logic               y_valid_reg;

    logic               accept;
    logic               start_job;
    logic               pipe_empty;

    // Tag pipe empty means no real row remains anywhere in the array.
    assign pipe_empty = ~|valid_pipe_reg;

    // -----------------------------------------------------------------------
    // Control FSM: next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        x_ready    = 1'b0;
        done       = 1'b0;
        busy       = (state_reg != ST_IDLE);
        start_job  = 1'b0;
        accept     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    start_job  = 1'b1;
                    state_next = (num_rows == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                x_ready = (in_cnt_reg < num_rows_q_reg);
                accept  = x_valid & x_ready;
                if (accept && ((in_cnt_reg + ROW_ONE) == num_rows_q_reg)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty && (out_cnt_reg == num_rows_q_reg)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers: state, counters and the valid-tag pipe
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            num_rows_q_reg <= '0;
            in_cnt_reg     <= '0;
            out_cnt_reg    <= '0;
            y_row_reg      <= '0;
            valid_pipe_reg <= '0;
            y_valid_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            // Bubble cycles shift in a 0 tag, so they never raise y_valid.
            valid_pipe_reg <= {valid_pipe_reg[DEPTH-2:0], accept};
            y_valid_reg    <= valid_pipe_reg[DEPTH-1];
            if (start_job) begin
                num_rows_q_reg <= num_rows;
                in_cnt_reg     <= '0;
                out_cnt_reg    <= '0;
            end else begin
                if (accept) begin
                    in_cnt_reg <= in_cnt_reg + ROW_ONE;
                end
                if (valid_pipe_reg[DEPTH-1]) begin
                    y_row_reg   <= out_cnt_reg;
                    out_cnt_reg <= out_cnt_reg + ROW_ONE;
                end
            end
        end
    end

    assign y_valid = y_valid_reg;
    assign y_row   = y_row_reg;

    // -----------------------------------------------------------------------
    // Input register plus skew: element i is delayed by i extra stages so it
    // meets the partial sum coming down column 0 at PE(i,0).
    // -----------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] x_link    [N][K];
    logic signed [ACC_WIDTH-1:0]  psum_link [N+1][K];

    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic signed [DATA_WIDTH-1:0] skew_reg [0:gi];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= gi; s++) begin
                    skew_reg[s] <= '0;
                end
            end else begin
                // A cycle without acceptance injects a zero row.
                skew_reg[0] <= accept ? X[DATA_WIDTH*gi +: DATA_WIDTH] : '0;
                for (int s = 1; s <= gi; s++) begin
                    skew_reg[s] <= skew_reg[s-1];
                end
            end
        end

        assign x_link[gi][0] = skew_reg[gi];
    end

    // Row 0 of the array starts from a zero partial sum.
    for (genvar gi = 0; gi < K; gi++) begin : g_psum_top
        assign psum_link[0][gi] = '0;
    end

    // -----------------------------------------------------------------------
    // Processing elements. Each PE holds its own weight for the whole job,
    // forwards x to the right and psum + x*w downwards.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < K; gj++) begin : g_pe
            logic signed [DATA_WIDTH-1:0] w_reg;
            logic signed [DATA_WIDTH-1:0] x_reg;
            logic signed [ACC_WIDTH-1:0]  psum_reg;
            logic signed [ACC_WIDTH-1:0]  x_ext;
            logic signed [ACC_WIDTH-1:0]  w_ext;
            logic signed [ACC_WIDTH-1:0]  prod;

            assign x_ext = {{(ACC_WIDTH-DATA_WIDTH){x_link[gi][gj][DATA_WIDTH-1]}}, x_link[gi][gj]};
            assign w_ext = {{(ACC_WIDTH-DATA_WIDTH){w_reg[DATA_WIDTH-1]}}, w_reg};
            // ACC_WIDTH-wide multiply keeps the low bits: wraps modulo 2^ACC_WIDTH.
            assign prod  = x_ext * w_ext;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    w_reg    <= '0;
                    x_reg    <= '0;
                    psum_reg <= '0;
                end else begin
                    if (start_job) begin
                        w_reg <= W[DATA_WIDTH*(gj*N+gi) +: DATA_WIDTH];
                    end
                    x_reg    <= x_link[gi][gj];
                    psum_reg <= psum_link[gi][gj] + prod;
                end
            end

            assign psum_link[gi+1][gj] = psum_reg;

            // The last column has no right-hand neighbour for x.
            if (gj < K-1) begin : g_fwd
                assign x_link[gi][gj+1] = x_reg;
            end else begin : g_sink
                logic unused_x;
                assign unused_x = ^x_reg;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Column deskew and output register. Column j finishes j cycles after
    // column 0, so it is delayed by K-1-j stages to line all columns up.
    // -----------------------------------------------------------------------
    for (genvar gj = 0; gj < K; gj++) begin : g_col_out
        localparam int DSK = K - 1 - gj;

        logic signed [ACC_WIDTH-1:0] col_raw;
        logic signed [ACC_WIDTH-1:0] col_act;
        logic signed [ACC_WIDTH-1:0] y_reg;

        if (DSK == 0) begin : g_nodsk
            assign col_raw = psum_link[N][gj];
        end else begin : g_dsk
            logic signed [ACC_WIDTH-1:0] dsk_reg [DSK];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < DSK; s++) begin
                        dsk_reg[s] <= '0;
                    end
                end else begin
                    dsk_reg[0] <= psum_link[N][gj];
                    for (int s = 1; s < DSK; s++) begin
                        dsk_reg[s] <= dsk_reg[s-1];
                    end
                end
            end

            assign col_raw = dsk_reg[DSK-1];
        end

`ifdef SYSTOLIC_RELU_EN
        assign col_act = col_raw[ACC_WIDTH-1] ? '0 : col_raw;
`else
        assign col_act = col_raw;
`endif

        // Y only updates on real rows and otherwise holds the last result.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                y_reg <= '0;
            end else if (valid_pipe_reg[DEPTH-1]) begin
                y_reg <= col_act;
            end
        end

        assign Y[ACC_WIDTH*gj +: ACC_WIDTH] = y_reg;
    end

endmodule

// File: tb/tb_systolic_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_systolic_stream_engine
//
// Randomised and directed jobs against a reference model that computes each
// result row directly as a matrix-vector product over plain integers. A
// negedge monitor predicts every output beat (value, row index and arrival
// cycle) from each accepted input beat and compares it with what appears.
// ---------------------------------------------------------------------------
module tb_systolic_stream_engine;

    localparam int N        = 3;
    localparam int K        = 4;
    localparam int DW       = 16;
    localparam int AW       = 32;
    localparam int MAX_ROWS = 256;
    localparam int ROW_W    = $clog2(MAX_ROWS + 1);
    localparam int LAT      = N + K;

    typedef logic [DW*N-1:0] row_t;

    typedef struct {
        logic [AW*K-1:0] y;
        int              row;
        int              cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [ROW_W-1:0]    num_rows = '0;
    logic [DW*N*K-1:0]   W = '0;
    logic                x_valid = 1'b0;
    logic                x_ready;
    row_t                X = '0;
    logic                y_valid;
    logic [AW*K-1:0]     Y;
    logic [ROW_W-1:0]    y_row;
    logic                busy;
    logic                done;

    systolic_stream_engine #(
        .N          (N),
        .K          (K),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .MAX_ROWS   (MAX_ROWS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_rows (num_rows),
        .W        (W),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .X        (X),
        .y_valid  (y_valid),
        .Y        (Y),
        .y_row    (y_row),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    logic signed [DW-1:0] w_m [N][K];
    exp_t exp_q[$];
    row_t rows[$];

    int job_acc       = 0;
    int y_seen        = 0;
    int done_seen     = 0;
    int last_y_cyc    = 0;
    int last_done_cyc = 0;
    int y_base        = 0;
    int done_base     = 0;
    int start_cyc     = 0;

    function automatic logic [AW*K-1:0] model_row(input row_t xv);
        logic [AW*K-1:0] r;
        longint          s;
        logic [63:0]     t64;
        logic [AW-1:0]   t;
        r = '0;
        for (int j = 0; j < K; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) begin
                s += longint'($signed(xv[DW*i +: DW])) * longint'(w_m[i][j]);
            end
            t64 = s;
            t   = t64[AW-1:0];
`ifdef SYSTOLIC_RELU_EN
            if (t[AW-1]) t = '0;
`endif
            r[AW*j +: AW] = t;
        end
        return r;
    endfunction

    function automatic logic [DW*N*K-1:0] rand_w();
        logic [DW*N*K-1:0] r;
        logic [31:0]       u;
        for (int b = 0; b < DW*N*K; b += 16) begin
            u = $urandom;
            r[b +: 16] = u[15:0];
        end
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t        r;
        logic [31:0] u;
        for (int b = 0; b < DW*N; b += 16) begin
            u = $urandom;
            r[b +: 16] = u[15:0];
        end
        return r;
    endfunction

    function automatic row_t pack3(input int a, input int b, input int c);
        return {c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    endfunction

    function automatic logic [DW*N*K-1:0] const_w(input int v);
        logic [DW*N*K-1:0] r;
        for (int e = 0; e < N*K; e++) r[DW*e +: DW] = v[DW-1:0];
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Monitor / scoreboard
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (y_valid) begin
                y_seen++;
                last_y_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_y_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("y_latency", cyc, e.cyc);
                    check("y_row", longint'(y_row), e.row);
                    for (int j = 0; j < K; j++) begin
                        check($sformatf("Y[%0d] row %0d", j, e.row),
                              longint'($signed(Y[AW*j +: AW])),
                              longint'($signed(e.y[AW*j +: AW])));
                    end
                end
            end
            if (done) begin
                done_seen++;
                last_done_cyc = cyc;
            end
            if (x_valid && x_ready) begin
                e.y   = model_row(X);
                e.row = job_acc;
                e.cyc = cyc + 1 + LAT;
                exp_q.push_back(e);
                job_acc++;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int nrows, input logic [DW*N*K-1:0] wv, input bit hold);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < K; j++)
                w_m[i][j] = wv[DW*(j*N+i) +: DW];
        job_acc   = 0;
        y_base    = y_seen;
        done_base = done_seen;
        start_cyc = cyc;
        start     = 1'b1;
        num_rows  = nrows[ROW_W-1:0];
        W         = wv;
        tick();
        if (!hold) start = 1'b0;
        // Changing W and num_rows mid-job must not disturb the running job.
        W        = rand_w();
        num_rows = ROW_W'($urandom_range(0, 20));
    endtask

    // mode 0: x_valid always high, 1: alternate 1,0,1,..., 2: random gaps
    task automatic feed(input int mode);
        int idx   = 0;
        int guard = 0;
        int ph    = 0;
        bit v;
        bit acc;
        while (idx < rows.size() && guard < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (ph % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            ph++;
            x_valid = v;
            X       = v ? rows[idx] : rand_row();
            @(negedge clk);
            acc = x_valid && x_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        x_valid = 1'b0;
        X       = '0;
        if (guard >= 2000) check("feed_timeout", 0, 1);
    endtask

    task automatic finish_job(input string name, input int nrows);
        int g = 0;
        while (done_seen == done_base && g < 200) begin
            @(negedge clk);
            #1;
            g++;
            if (done) begin
                start   = 1'b0;
                x_valid = 1'b0;
            end
        end
        repeat (4) tick();
        check({name, ":done_pulses"}, done_seen - done_base, 1);
        check({name, ":y_beats"}, y_seen - y_base, nrows);
        check({name, ":done_cycle"}, last_done_cyc,
              (nrows > 0) ? last_y_cyc + 1 : start_cyc + 1);
        check({name, ":idle_busy"}, longint'(busy), 0);
    endtask

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    initial begin
        logic [DW*N*K-1:0] wv;
        int                nr;
        int                yb;
        int                db;
        longint            exp_v;

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        check("rst:busy", longint'(busy), 0);
        check("rst:x_ready", longint'(x_ready), 0);
        check("rst:y_valid", longint'(y_valid), 0);
        check("rst:done", longint'(done), 0);
        check("rst:y_row", longint'(y_row), 0);
        check("rst:Y", longint'(Y[63:0]), 0);
        rst = 1'b1;
        tick();

        // Basic job: W(i,j)=i+j+1
        for (int i = 0; i < N; i++)
            for (int j = 0; j < K; j++)
                wv[DW*(j*N+i) +: DW] = DW'(i + j + 1);
        rows.delete();
        rows.push_back(pack3(1, 2, 3));
        rows.push_back(pack3(0, 0, 0));
        rows.push_back(pack3(-1, 1, 2));
        start_job(3, wv, 1'b0);
        check("basic:busy", longint'(busy), 1);
        feed(0);
        finish_job("basic", 3);
        for (int j = 0; j < K; j++)
            check($sformatf("basic:hold_Y[%0d]", j), longint'($signed(Y[AW*j +: AW])), 7 + 2*j);
        check("basic:hold_y_row", longint'(y_row), 2);

        // Same job with bubbles 1,0,1,0,1
        start_job(3, wv, 1'b0);
        feed(1);
        finish_job("bubble", 3);

        // Zero-row job
        start_job(0, wv, 1'b0);
        finish_job("zero", 0);

        // Wrap: all -32768
        rows.delete();
        rows.push_back(pack3(-32768, -32768, -32768));
        start_job(1, const_w(-32768), 1'b0);
        feed(0);
        finish_job("wrap", 1);
`ifdef SYSTOLIC_RELU_EN
        exp_v = 0;
`else
        exp_v = -1073741824;
`endif
        check("wrap:Y0", longint'($signed(Y[AW-1:0])), exp_v);
        check("wrap:Y3", longint'($signed(Y[AW*3 +: AW])), exp_v);

        // Negative result: X=1, W=-1
        rows.delete();
        rows.push_back(pack3(1, 1, 1));
        start_job(1, const_w(-1), 1'b0);
        feed(0);
        finish_job("neg", 1);
`ifdef SYSTOLIC_RELU_EN
        exp_v = 0;
`else
        exp_v = -3;
`endif
        check("neg:Y0", longint'($signed(Y[AW-1:0])), exp_v);

        // Protocol: start held, x_valid kept high after the last row
        rows.delete();
        rows.push_back(rand_row());
        rows.push_back(rand_row());
        start_job(2, rand_w(), 1'b1);
        feed(0);
        x_valid = 1'b1;
        X       = rand_row();
        repeat (4) begin
            @(negedge clk);
            check("proto:x_ready", longint'(x_ready), 0);
            check("proto:busy", longint'(busy), 1);
        end
        finish_job("proto", 2);

        // Reset in the middle of a 5-row job, after 2 rows
        rows.delete();
        rows.push_back(rand_row());
        rows.push_back(rand_row());
        start_job(5, rand_w(), 1'b0);
        feed(0);
        yb = y_seen;
        db = done_seen;
        rst = 1'b0;
        #1;
        check("abort:busy", longint'(busy), 0);
        check("abort:x_ready", longint'(x_ready), 0);
        check("abort:y_valid", longint'(y_valid), 0);
        check("abort:done", longint'(done), 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (15) tick();
        check("abort:no_done", done_seen - db, 0);
        check("abort:no_y", y_seen - yb, 0);
        rows.delete();
        rows.push_back(rand_row());
        start_job(1, rand_w(), 1'b0);
        feed(0);
        finish_job("after_abort", 1);

        // Random jobs with random gaps
        for (int t = 0; t < 6; t++) begin
            nr = $urandom_range(1, 10);
            rows.delete();
            for (int r = 0; r < nr; r++) rows.push_back(rand_row());
            start_job(nr, rand_w(), 1'b0);
            feed(2);
            finish_job($sformatf("rand%0d", t), nr);
        end

        check("end:queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
